// File: rtl/result_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : result_tx_sequencer
//  Purpose  : Streams inference results to a UART transmitter once inference
//             completes: the predicted digit byte first, then NUM_SCORE_BYTES
//             little-endian score bytes, one byte per tx_start/tx_busy
//             handshake. Owns the read ports of both result RAMs.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             start             - readout request pulse (accepted in idle only)
//             busy, done        - stream in progress / one-cycle completion
//             digit_rd_addr     - digit RAM read address (always 0)
//             digit_rd_data     - digit RAM registered read data
//             score_rd_addr     - score RAM read address
//             score_rd_data     - score RAM registered read data
//             tx_data, tx_start - byte and request to the UART transmitter
//             tx_busy           - UART transmitter busy
//  Options  : RESULT_TX_CHECKSUM_EN - append an XOR checksum byte to the stream
//  Revision : 1.0 - initial release
// ============================================================================
module result_tx_sequencer #(
    parameter int NUM_SCORE_BYTES = 40,
    parameter int ADDR_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              digit_rd_addr,
    input  logic [7:0]        digit_rd_data,
    output logic [ADDR_W-1:0] score_rd_addr,
    input  logic [7:0]        score_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_SET_ADDR = 3'd1;
    localparam logic [2:0] c_S_WAIT_RD  = 3'd2;
    localparam logic [2:0] c_S_LOAD     = 3'd3;
    localparam logic [2:0] c_S_SEND     = 3'd4;
    localparam logic [2:0] c_S_WAIT_ACK = 3'd5;
    localparam logic [2:0] c_S_WAIT_TX  = 3'd6;
    localparam logic [2:0] c_S_FINISH   = 3'd7;

    // Counter value of the last score byte; one bit wider than the address
    // so that the digit slot (0) plus all score slots fit without wrapping.
    localparam logic [ADDR_W:0]   c_LAST_CNT = NUM_SCORE_BYTES[ADDR_W:0];
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]      r_state;
    logic [ADDR_W:0] r_cnt;

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]      r_csum;
    logic            r_csum_sent;
`endif

    // Only one digit byte exists, so its RAM is always read at address 0.
    assign digit_rd_addr = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_cnt         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            score_rd_addr <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            r_csum        <= '0;
            r_csum_sent   <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses fall back unless re-asserted below.
            done     <= 1'b0;
            tx_start <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_cnt         <= '0;
                        score_rd_addr <= '0;
                        busy          <= 1'b1;
                        r_state       <= c_S_SET_ADDR;
`ifdef RESULT_TX_CHECKSUM_EN
                        r_csum        <= '0;
                        r_csum_sent   <= 1'b0;
`endif
                    end
                end

                c_S_SET_ADDR: begin
                    // Slot 0 is the digit; slot k reads score byte k-1.
                    if (r_cnt != '0) begin
                        score_rd_addr <= r_cnt[ADDR_W-1:0] - c_ADDR_ONE;
                    end
                    r_state <= c_S_WAIT_RD;
                end

                // The RAM registers the address at the end of this cycle.
                c_S_WAIT_RD: r_state <= c_S_LOAD;

                c_S_LOAD: begin
                    tx_data <= (r_cnt == '0) ? digit_rd_data : score_rd_data;
                    r_state <= c_S_SEND;
                end

                c_S_SEND: begin
                    // Never launch on top of a transmission still in flight.
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        r_state  <= c_S_WAIT_ACK;
`ifdef RESULT_TX_CHECKSUM_EN
                        r_csum   <= r_csum ^ tx_data;
`endif
                    end
                end

                c_S_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= c_S_WAIT_TX;
                    end
                end

                c_S_WAIT_TX: begin
                    if (!tx_busy) begin
                        if (r_cnt == c_LAST_CNT) begin
`ifdef RESULT_TX_CHECKSUM_EN
                            if (!r_csum_sent) begin
                                // Data byte already staged, go straight to SEND.
                                tx_data     <= r_csum;
                                r_csum_sent <= 1'b1;
                                r_state     <= c_S_SEND;
                            end else begin
                                r_state     <= c_S_FINISH;
                            end
`else
                            r_state <= c_S_FINISH;
`endif
                        end else begin
                            r_cnt   <= r_cnt + c_CNT_ONE;
                            r_state <= c_S_SET_ADDR;
                        end
                    end
                end

                c_S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_S_IDLE;
                end

                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
Sequences readout of inference results over UART once inference completes. On `start`, the block reads the predicted digit byte from predicted_digit_ram, then the 40 little-endian score bytes from scores_ram. Each byte goes to the UART transmitter through a tx_start/tx_busy handshake. It sits between the inference core's done pulse and the uart_tx instance, and owns the read ports of both result RAMs.

Parameters:
- NUM_SCORE_BYTES, 40: score bytes to stream; score addresses 0..NUM_SCORE_BYTES-1.
- ADDR_W, 6: width of score_rd_addr; must satisfy 2^ADDR_W >= NUM_SCORE_BYTES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a readout; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte's transmission completes.
- digit_rd_addr  out  1  predicted_digit_ram read address; constant 0.
- digit_rd_data  in  8  predicted_digit_ram registered read data.
- score_rd_addr  out  ADDR_W  scores_ram read address.
- score_rd_data  in  8  scores_ram registered read data.
- tx_data  out  8  byte to transmit; held stable while tx_start is high.
- tx_start  out  1  one-cycle request to the UART transmitter.
- tx_busy  in  1  UART busy; rises the cycle after tx_start is accepted, falls when the stop bit ends.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0.
- RAM latency: RAM read data is valid 1 cycle after the address is presented. The block must wait exactly one cycle after setting the address before capturing data.
- Stream order:
  - Byte 0 is the digit.
  - Bytes 1..NUM_SCORE_BYTES come from score_rd_addr 0..NUM_SCORE_BYTES-1.
  - Total 41 bytes at defaults.
- FSM states: IDLE, SET_ADDR, WAIT_RD, LOAD, SEND, WAIT_ACK, WAIT_TX, FINISH.
  - IDLE: on start=1, go to SET_ADDR; clear the counter; busy=1 next cycle.
  - SET_ADDR: drive the address. Counter 0 selects the digit RAM; counter k>0 sets score_rd_addr=k-1.
  - WAIT_RD: one wait cycle.
  - LOAD: tx_data <= digit_rd_data if counter==0, else score_rd_data.
  - SEND: wait until tx_busy==0, then assert tx_start for exactly 1 cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy==1.
  - WAIT_TX: wait for tx_busy==0. Then, if counter==NUM_SCORE_BYTES, go to FINISH; else increment the counter and go to SET_ADDR.
  - FINISH: done=1 for 1 cycle, busy=0 next cycle, go to IDLE.
- score_rd_addr holds its last value between bytes. It returns to 0 only on reset or a new start.
- Counter width is ADDR_W+1; it never wraps at default parameters.
- start while busy=1: ignored; no restart and no queuing.
- start in the same cycle as FINISH: ignored; start is accepted only in IDLE.
- tx_busy already high when SEND is entered: hold in SEND without asserting tx_start.
- Reset mid-stream: immediate return to IDLE. tx_start and busy drop asynchronously, and no done pulse is emitted.
- Results integrity: the block does not lock the RAMs. The issuer must pulse start only after the scores/digit write enables have fired. A write during streaming is a system-level error with undefined byte content.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- Defined:
  - A running XOR of every byte sent, including the digit, is accumulated in an 8-bit register, cleared on start.
  - After the last score byte, one extra byte equal to the XOR is sent through SEND/WAIT_ACK/WAIT_TX, then FINISH.
  - Total is 42 bytes at defaults.
- Undefined: no accumulator is built; the stream is exactly 1+NUM_SCORE_BYTES bytes.

Test Plan:
- Digit RAM=0x07, scores all 0 except class 3 = 0x12345678, UART model busy 10 cycles per byte, pulse start.
  - tx_data sequence: 07, then twelve 00, then 78 56 34 12, then 24 more 00 (41 bytes).
  - Exactly one done pulse after the 41st tx_busy fall; busy low afterwards.
- Check each tx_start.
  - Exactly 1 cycle wide.
  - tx_data stable during it.
  - Never asserted while tx_busy=1.
  - score_rd_addr observed 0..39 in order.
- Pulse start again at byte 5 and at the FINISH cycle: stream unchanged, still 41 bytes, single done.
- Assert rst while waiting on byte 20: tx_start=0, busy=0 the same cycle. A fresh start afterwards yields a full 41-byte stream from byte 0.
- Hold tx_busy=1 externally for 50 cycles before the first SEND: no tx_start until it falls, then normal stream.
- With RESULT_TX_CHECKSUM_EN, digit 0x07 and the same scores as scenario 1:
  - 42 bytes; final byte = 07^78^56^34^12 = 0x0F.
  - done only after the 42nd byte.
